// File: rtl/mem_copy_engine_pkg.sv
// mem_pkg: shared widths, byte type and copy-engine state encoding.
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef logic [7:0] byte_t;
  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} copy_state_t;
endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: 256x8 data-memory port with combinational read data.
interface mem_copy_engine_if;
  import mem_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master (output addr, output we, output wdata, input rdata);
  modport slave (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy/fill over the data memory with a mod-256 checksum of written bytes.
module mem_copy_engine
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  byte_t             i_len,
  input  logic [DATA_W-1:0] i_fill_val,
  mem_copy_engine_if.master mem,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_sum
);
  copy_state_t       r_state, w_next;
  logic [ADDR_W-1:0] r_src, r_dst;
  byte_t             r_cnt;
  logic [DATA_W-1:0] r_data, r_fill, r_sum;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (i_start) begin
          r_src  <= i_src_addr;
          r_dst  <= i_dst_addr;
          r_cnt  <= i_len;
          r_fill <= i_fill_val;
          r_sum  <= '0;
        end
        RD: r_data <= mem.rdata;
        WR: begin
          r_sum <= r_sum + r_data;
          r_src <= r_src + 1'b1;
          r_dst <= r_dst + 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        FILL: begin
          r_sum <= r_sum + r_fill;
          r_dst <= r_dst + 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
  // Reset gates every port output so a reset landing on a write cycle suppresses that write.
  always_comb begin
    w_next    = r_state;
    mem.addr  = '0;
    mem.we    = 1'b0;
    mem.wdata = '0;
    if (!i_rst) case (r_state)
      IDLE: w_next = !i_start ? IDLE : i_len == '0 ? DONE : i_mode ? FILL : RD;
      RD: begin
        mem.addr = r_src;
        w_next   = WR;
      end
      WR: begin
        mem.addr  = r_dst;
        mem.wdata = r_data;
        mem.we    = 1'b1;
        w_next    = r_cnt == 8'd1 ? DONE : RD;
      end
      FILL: begin
        mem.addr  = r_dst;
        mem.wdata = r_fill;
        mem.we    = 1'b1;
        w_next    = r_cnt == 8'd1 ? DONE : FILL;
      end
      default: w_next = IDLE;
    endcase
  end
  assign o_busy = !i_rst && r_state != IDLE;
  assign o_done = !i_rst && r_state == DONE;
  assign o_sum  = i_rst ? '0 : r_sum;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed and random copy/fill runs against a byte-array reference model.
module tb_mem_copy_engine;
  import mem_pkg::*;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [7:0] src = '0, dst = '0, len = '0, fill = '0;
  logic       busy, done;
  logic [7:0] sum;
  int         n_chk = 0, fails = 0, n_wr = 0, n_busy = 0;
  logic       ld = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] ld_img [256];
  logic [7:0] ref_mem [256];

  mem_copy_engine_if ifc();
  mem_copy_engine dut (.i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_src_addr(src), .i_dst_addr(dst), .i_len(len), .i_fill_val(fill),
    .mem(ifc), .o_busy(busy), .o_done(done), .o_sum(sum));

  always #5 clk = ~clk;

  // DataMem responder
  assign ifc.rdata = mem[ifc.addr];
  always @(posedge clk) begin
    if (ld) mem <= ld_img;
    else if (ifc.we) mem[ifc.addr] <= ifc.wdata;
    if (ifc.we) n_wr <= n_wr + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load();
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
    ref_mem = ld_img;
  endtask

  task automatic chk_mem(input string tag);
    int bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
    chk({tag, " first bad addr"}, bad, -1);
  endtask

  task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, input logic [7:0] f, input bit spam, input string tag);
    int lat, exp_lat, w0, b0;
    logic [7:0] es = '0;
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] v;
      v = m ? f : ref_mem[8'(int'(s) + i)];
      ref_mem[8'(int'(d) + i)] = v;
      es += v;
    end
    exp_lat = (l == 0) ? 1 : m ? int'(l) + 1 : 2 * int'(l) + 1;
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
    w0 = n_wr; b0 = n_busy;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 1000) begin
      start = spam;
      if (spam) begin dst = d + 8'h33; mode = ~m; len = l + 8'd1; end
      @(negedge clk);
      lat++;
    end
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " sum"}, int'(sum), int'(es));
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after"}, int'(busy), 0);
    chk({tag, " done pulse"}, int'(done), 0);
    chk({tag, " sum held"}, int'(sum), int'(es));
    chk({tag, " writes"}, n_wr - w0, int'(l));
    chk({tag, " busy cycles"}, n_busy - b0, exp_lat);
    chk_mem(tag);
  endtask

  initial begin
    int nw, g, w0;
    for (int i = 0; i < 256; i++) ld_img[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst sum", int'(sum), 0);
    chk("rst we", int'(ifc.we), 0);
    chk("rst addr", int'(ifc.addr), 0);
    chk("rst wdata", int'(ifc.wdata), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ld_img[8'h10 + i] = 8'(i + 1);
    load();
    run(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 1'b0, "copy");
    chk("copy sum const", int'(sum), 8'h0A);
    run(1'b1, 8'h00, 8'hFE, 8'd3, 8'hAA, 1'b0, "fill wrap");
    chk("fill wrap mem00", int'(mem[0]), 8'hAA);
    run(1'b0, 8'h05, 8'h06, 8'd0, 8'h00, 1'b0, "len0");
    ld_img = ref_mem;
    ld_img[8'h20] = 8'h11; ld_img[8'h21] = 8'h22; ld_img[8'h22] = 8'h33;
    load();
    run(1'b0, 8'h20, 8'h21, 8'd2, 8'h00, 1'b0, "overlap");
    chk("overlap mem22", int'(mem[8'h22]), 8'h11);
    run(1'b0, 8'h30, 8'h90, 8'd5, 8'h00, 1'b1, "ignored start");
    run(1'b1, 8'h00, 8'hA0, 8'd0, 8'h5C, 1'b1, "ignored start len0");
    // Reset lands on the third write of an 8-byte copy: only two bytes may reach memory.
    for (int i = 0; i < 2; i++) ref_mem[8'hC0 + i] = ref_mem[8'h80 + i];
    @(negedge clk);
    mode = 1'b0; src = 8'h80; dst = 8'hC0; len = 8'd8; start = 1'b1; w0 = n_wr;
    @(negedge clk);
    start = 1'b0; nw = 0; g = 0;
    while (nw < 3 && g < 100) begin
      if (ifc.we) nw++;
      if (nw < 3) @(negedge clk);
      g++;
    end
    chk("midrst reached WR", nw, 3);
    rst = 1'b1;
    #1;
    chk("midrst we during", int'(ifc.we), 0);
    chk("midrst busy during", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst sum", int'(sum), 0);
    chk("midrst we", int'(ifc.we), 0);
    chk("midrst writes", n_wr - w0, 2);
    chk_mem("midrst");
    run(1'b0, 8'h80, 8'hC0, 8'd8, 8'h00, 1'b0, "after reset");
    for (int k = 0; k < 20; k++) begin
      logic [7:0] rl;
      rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 20));
      run(1'($urandom), 8'($urandom), 8'($urandom), rl, 8'($urandom), 1'($urandom), $sformatf("rand%0d", k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
    $finish;
  end
endmodule
